// File: rtl/keypad_interface_pkg.sv
// keypad_interface_pkg
//   Shared definitions for the keypad scanner: FSM state encoding, hex key
//   code constants, default divider/debounce settings and small row-pattern
//   helpers used by the scanner FSM.
`timescale 1ns/1ps
package keypad_interface_pkg;

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    DEBOUNCE = 2'd1,
    HELD     = 2'd2,
    RELEASE  = 2'd3
  } kp_state_e;

  localparam int SCAN_DIV_DEF       = 2048;
  localparam int DEBOUNCE_TICKS_DEF = 16;

  localparam logic [3:0] KEY_0 = 4'h0, KEY_1 = 4'h1, KEY_2 = 4'h2, KEY_3 = 4'h3;
  localparam logic [3:0] KEY_4 = 4'h4, KEY_5 = 4'h5, KEY_6 = 4'h6, KEY_7 = 4'h7;
  localparam logic [3:0] KEY_8 = 4'h8, KEY_9 = 4'h9, KEY_A = 4'hA, KEY_B = 4'hB;
  localparam logic [3:0] KEY_C = 4'hC, KEY_D = 4'hD, KEY_E = 4'hE, KEY_F = 4'hF;

  // exactly one row line pulled low
  function automatic logic row_valid(input logic [3:0] r);
    return $countones(~r) == 1;
  endfunction

  // index of the low row line (only meaningful when row_valid)
  function automatic logic [1:0] row_index(input logic [3:0] r);
    logic [1:0] idx;
    idx = '0;
    for (int i = 0; i < 4; i++)
      if (!r[i]) idx = 2'(i);
    return idx;
  endfunction

endpackage

// File: rtl/keypad_interface_decode.sv
// keypad_decode
//   Combinational map from matrix position to hex key code.
//   rowIdx : row of the pressed key (0..3)
//   colIdx : column of the pressed key (0..3)
//   hex    : key code
`timescale 1ns/1ps
module keypad_decode
  import keypad_interface_pkg::*;
(
  input  logic [1:0] rowIdx,
  input  logic [1:0] colIdx,
  output logic [3:0] hex
);

  always_comb begin
    hex = KEY_0;
    case ({rowIdx, colIdx})
      4'h0: hex = KEY_1;
      4'h1: hex = KEY_2;
      4'h2: hex = KEY_3;
      4'h3: hex = KEY_A;
      4'h4: hex = KEY_4;
      4'h5: hex = KEY_5;
      4'h6: hex = KEY_6;
      4'h7: hex = KEY_B;
      4'h8: hex = KEY_7;
      4'h9: hex = KEY_8;
      4'hA: hex = KEY_9;
      4'hB: hex = KEY_C;
      4'hC: hex = KEY_0;
      4'hD: hex = KEY_F;
      4'hE: hex = KEY_E;
      4'hF: hex = KEY_D;
      default: hex = KEY_0;
    endcase
  end

endmodule

// File: rtl/keypad_interface.sv
// keypad_interface
//   Scans a 4x4 active-low matrix keypad and reports one debounced key code
//   per physical press.
//   clk5    : 5 MHz system clock
//   reset   : synchronous, active-high
//   row     : keypad rows, active low, asynchronous
//   col     : column drive, one-hot active low
//   keycode : last accepted key, held until the next press
//   newkey  : one-cycle pulse when keycode updates
//   keyDown : high while the accepted key is still held
`timescale 1ns/1ps
module keypad_interface
  import keypad_interface_pkg::*;
#(
  parameter int SCAN_DIV       = SCAN_DIV_DEF,
  parameter int DEBOUNCE_TICKS = DEBOUNCE_TICKS_DEF
) (
  input  logic       clk5,
  input  logic       reset,
  input  logic [3:0] row,
  output logic [3:0] col,
  output logic [3:0] keycode,
  output logic       newkey,
  output logic       keyDown
);

  localparam int DW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam int CW = (DEBOUNCE_TICKS > 2) ? $clog2(DEBOUNCE_TICKS) : 1;
  // counters compare one short of the target because the entry tick
  // (detection / first high tick) already counts as tick 1
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_TICKS - 2);
  localparam logic [DW-1:0] DIV_LAST = DW'(SCAN_DIV - 1);

  logic [DW-1:0] divCnt;
  logic          tick;
  logic [3:0]    rowM, rowS;
  kp_state_e     state;
  logic [1:0]    colIdx, rowIdx;
  logic [CW-1:0] debCnt, relCnt;
  logic [3:0]    decHex;

  // scan tick divider
  always_ff @(posedge clk5) begin
    if (reset) begin
      divCnt <= '0;
      tick   <= 1'b0;
    end else begin
      tick   <= (divCnt == DIV_LAST);
      divCnt <= (divCnt == DIV_LAST) ? '0 : divCnt + 1'b1;
    end
  end

  // row synchroniser
  always_ff @(posedge clk5) begin
    if (reset) begin
      rowM <= 4'hF;
      rowS <= 4'hF;
    end else begin
      rowM <= row;
      rowS <= rowM;
    end
  end

  keypad_decode u_dec (
    .rowIdx (rowIdx),
    .colIdx (colIdx),
    .hex    (decHex)
  );

  assign col = ~(4'b0001 << colIdx);

  always_ff @(posedge clk5) begin
    if (reset) begin
      state   <= SCAN;
      colIdx  <= '0;
      rowIdx  <= '0;
      debCnt  <= '0;
      relCnt  <= '0;
      keycode <= KEY_0;
      newkey  <= 1'b0;
      keyDown <= 1'b0;
    end else begin
      newkey <= 1'b0;
      if (tick) begin
        case (state)
          SCAN: begin
            if (row_valid(rowS)) begin
              rowIdx <= row_index(rowS);
              debCnt <= '0;
              state  <= DEBOUNCE;
            end else begin
              colIdx <= colIdx + 1'b1;
            end
          end
          DEBOUNCE: begin
            if (rowS == ~(4'b0001 << rowIdx)) begin
              if (debCnt == CNT_LAST) begin
                state   <= HELD;
                keycode <= decHex;
                newkey  <= 1'b1;
                keyDown <= 1'b1;
              end else begin
                debCnt <= debCnt + 1'b1;
              end
            end else begin
              state  <= SCAN;
              colIdx <= colIdx + 1'b1;
            end
          end
          HELD: begin
            // no auto-repeat: stay here until the rows go quiet
            if (rowS == 4'hF) begin
              relCnt <= '0;
              state  <= RELEASE;
            end
          end
          RELEASE: begin
            if (rowS != 4'hF) begin
              state <= HELD;
            end else if (relCnt == CNT_LAST) begin
              keyDown <= 1'b0;
              colIdx  <= colIdx + 1'b1;
              state   <= SCAN;
            end else begin
              relCnt <= relCnt + 1'b1;
            end
          end
          default: state <= SCAN;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_keypad_interface.sv
`timescale 1ns/1ps
module tb_keypad_interface;
  localparam int SD = 8;
  localparam int DT = 3;

  logic       clk5 = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] row, col, keycode;
  logic       newkey, keyDown;
  logic [3:0][3:0] pressed = '0;   // pressed[r][c]

  always #5 clk5 = ~clk5;

  // pulled-up matrix: a row reads low when a pressed key in it sits on a driven column
  always_comb begin
    row = 4'hF;
    for (int r = 0; r < 4; r++) row[r] = ~|(pressed[r] & ~col);
  end

  keypad_interface #(.SCAN_DIV(SD), .DEBOUNCE_TICKS(DT)) dut (
    .clk5(clk5), .reset(reset), .row(row), .col(col),
    .keycode(keycode), .newkey(newkey), .keyDown(keyDown)
  );

  typedef struct { int r; int c; logic [3:0] code; } vec_t;
  vec_t tbl[16];

  int checks = 0, errors = 0, cyc = 0, nk = 0, base = 0;

  initial begin
    #2000000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // every bench step goes through here so newkey pulses are counted once each
  task automatic tick_clk();
    @(negedge clk5);
    cyc++;
    if (newkey) nk++;
  endtask

  // advance to the negedge just after the next scan-tick sample
  task automatic post();
    do tick_clk(); while (cyc % SD != 1);
  endtask

  function automatic logic [3:0] colpat(input int i);
    logic [3:0] one;
    one = 4'b0001;
    return ~(one << (i % 4));
  endfunction

  task automatic wait_col(input logic [3:0] c);
    for (int i = 0; i < 8; i++) begin
      post();
      if (col == c) return;
    end
    chk("wait_col", col, c);
  endtask

  initial begin
    tbl[0]  = '{0,0,4'h1}; tbl[1]  = '{0,1,4'h2}; tbl[2]  = '{0,2,4'h3}; tbl[3]  = '{0,3,4'hA};
    tbl[4]  = '{1,0,4'h4}; tbl[5]  = '{1,1,4'h5}; tbl[6]  = '{1,2,4'h6}; tbl[7]  = '{1,3,4'hB};
    tbl[8]  = '{2,0,4'h7}; tbl[9]  = '{2,1,4'h8}; tbl[10] = '{2,2,4'h9}; tbl[11] = '{2,3,4'hC};
    tbl[12] = '{3,0,4'h0}; tbl[13] = '{3,1,4'hF}; tbl[14] = '{3,2,4'hE}; tbl[15] = '{3,3,4'hD};

    // 1. reset values and free-running column scan
    repeat (3) tick_clk();
    chk("rst_col", col, 4'b1110);
    chk("rst_keycode", keycode, 4'h0);
    chk("rst_newkey", newkey, 1'b0);
    chk("rst_keyDown", keyDown, 1'b0);
    reset = 1'b0;
    cyc = 0;
    for (int k = 1; k <= 4; k++) begin
      while (cyc < SD * k) tick_clk();
      chk("col_hold", col, colpat(k - 1));
      tick_clk();
      chk("col_step", col, colpat(k));
    end

    // 2. key 5 pressed and held: latency, single pulse, frozen column
    wait_col(4'b1101);
    base = nk;
    pressed[1][1] = 1'b1;
    repeat (2) post();
    chk("k5_early", nk - base, 0);
    post();
    chk("k5_latency", nk - base, 1);
    repeat (3) post();
    chk("k5_pulses", nk - base, 1);
    chk("k5_code", keycode, 4'h5);
    chk("k5_down", keyDown, 1'b1);
    chk("k5_col", col, 4'b1101);
    pressed = '0;
    repeat (6) post();
    chk("k5_up", keyDown, 1'b0);

    // 3. one-tick bounce on row1
    wait_col(4'b1101);
    base = nk;
    pressed[1][1] = 1'b1;
    repeat (SD) tick_clk();
    pressed = '0;
    repeat (4) tick_clk();
    chk("bounce_frozen", col, 4'b1101);
    repeat (5) tick_clk();
    chk("bounce_resume", col, 4'b1011);
    chk("bounce_nonew", nk - base, 0);
    chk("bounce_code", keycode, 4'h5);

    // 4. release with a one-tick low glitch after two high ticks
    wait_col(4'b1101);
    pressed[1][1] = 1'b1;
    repeat (4) post();
    chk("gl_down", keyDown, 1'b1);
    base = nk;
    pressed = '0;
    repeat (2 * SD) tick_clk();
    pressed[1][1] = 1'b1;
    repeat (SD) tick_clk();
    chk("gl_held1", keyDown, 1'b1);
    pressed = '0;
    repeat (2 * SD) tick_clk();
    chk("gl_held2", keyDown, 1'b1);
    repeat (SD - 1) tick_clk();
    chk("gl_held3", keyDown, 1'b1);
    tick_clk();
    chk("gl_released", keyDown, 1'b0);
    chk("gl_col", col, 4'b1011);
    chk("gl_nonew", nk - base, 0);

    // 5. two rows low together on one column is ignored
    wait_col(4'b1110);
    base = nk;
    pressed[1][1] = 1'b1;
    pressed[2][1] = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      post();
      chk("multi_col", col, colpat(k));
    end
    chk("multi_nonew", nk - base, 0);
    pressed = '0;
    post();

    // 6. reset during HELD for key D
    wait_col(4'b0111);
    base = nk;
    pressed[3][3] = 1'b1;
    repeat (4) post();
    chk("kd_code", keycode, 4'hD);
    chk("kd_pulses", nk - base, 1);
    reset = 1'b1;
    tick_clk();
    chk("mrst_col", col, 4'b1110);
    chk("mrst_keycode", keycode, 4'h0);
    chk("mrst_keyDown", keyDown, 1'b0);
    chk("mrst_newkey", newkey, 1'b0);
    pressed = '0;
    tick_clk();
    reset = 1'b0;
    cyc = 0;
    base = nk;
    repeat (10) post();
    chk("mrst_nonew", nk - base, 0);
    chk("mrst_keep0", keycode, 4'h0);

    // table: every key position decodes to its hex value
    for (int i = 0; i < 16; i++) begin
      base = nk;
      pressed[tbl[i].r][tbl[i].c] = 1'b1;
      repeat (10) post();
      chk("tbl_code", keycode, tbl[i].code);
      chk("tbl_once", nk - base, 1);
      chk("tbl_down", keyDown, 1'b1);
      pressed = '0;
      repeat (6) post();
      chk("tbl_up", keyDown, 1'b0);
    end

    // random: unaligned presses of random keys, long stable holds and releases
    for (int n = 0; n < 10; n++) begin
      int i;
      i = int'($urandom_range(0, 15));
      repeat (int'($urandom_range(0, 7))) tick_clk();
      base = nk;
      pressed[tbl[i].r][tbl[i].c] = 1'b1;
      repeat (SD * int'($urandom_range(9, 14))) tick_clk();
      chk("rnd_code", keycode, tbl[i].code);
      chk("rnd_once", nk - base, 1);
      chk("rnd_down", keyDown, 1'b1);
      pressed = '0;
      repeat (SD * int'($urandom_range(6, 9))) tick_clk();
      chk("rnd_up", keyDown, 1'b0);
      chk("rnd_once_after", nk - base, 1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
